// File: rtl/ram_bus_pkg.sv
// rtl/ram_bus_pkg.sv - shared types and defaults for the RAM bus initiator
package ram_bus_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_ADDR  = 3'd2,
        ST_RD_DATA  = 3'd3,
        ST_VFY_ADDR = 3'd4,
        ST_VFY_DATA = 3'd5
    } ram_bus_state_t;

    // States in which the RAM is expected to drive the data bus
    function automatic logic state_oe(input ram_bus_state_t s);
        return (s == ST_RD_DATA) || (s == ST_VFY_DATA);
    endfunction

    function automatic logic state_we(input ram_bus_state_t s);
        return (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/ram_bus_master.sv
// rtl/ram_bus_master.sv - single-port RAM bus initiator with registered strobes
// Optional feature: define RAM_WR_VERIFY_EN for read-back verification of every write.
module ram_bus_master
    import ram_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic                  vfy_err,
    output logic                  vfy_err_sticky
);

    ram_bus_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic                  vfy_err_d, vfy_sticky_d;
    logic                  xfer;

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign xfer      = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rsp_valid_d  = 1'b0;
        vfy_err_d    = 1'b0;
        vfy_sticky_d = vfy_err_sticky;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? ST_WRITE : ST_RD_ADDR;
                end
            end
            ST_WRITE: begin
`ifdef RAM_WR_VERIFY_EN
                state_d = ST_VFY_ADDR;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RD_ADDR: state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                rdata_d     = mem_data;
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
`ifdef RAM_WR_VERIFY_EN
            ST_VFY_ADDR: state_d = ST_VFY_DATA;
            ST_VFY_DATA: begin
                if (mem_data != wdata_q) begin
                    vfy_err_d    = 1'b1;
                    vfy_sticky_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // Strobes follow the next state so they are registered alongside it
        cs_d = (state_d != ST_IDLE);
        we_d = state_we(state_d);
        oe_d = state_oe(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
        end
    end

`ifdef RAM_WR_VERIFY_EN
    logic vfy_err_q, vfy_sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vfy_err_q    <= 1'b0;
            vfy_sticky_q <= 1'b0;
        end else begin
            vfy_err_q    <= vfy_err_d;
            vfy_sticky_q <= vfy_sticky_d;
        end
    end

    assign vfy_err        = vfy_err_q;
    assign vfy_err_sticky = vfy_sticky_q;
`else
    assign vfy_err        = 1'b0;
    assign vfy_err_sticky = 1'b0;

    logic unused_vfy;
    assign unused_vfy = vfy_err_d ^ vfy_sticky_d;
`endif

    // Bus is driven only by the registered write strobe, which is never high with oe
    assign mem_data    = we_q ? wdata_q : {DATA_WIDTH{1'bz}};

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign mem_address = addr_q;
    assign mem_cs      = cs_q;
    assign mem_we      = we_q;
    assign mem_oe      = oe_q;

endmodule
